// File: rtl/graph_record_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : graph_pkg
// Description : Shared types and constants for the graph fetch/drain path:
//               default vertex geometry, drain FSM state encoding and a
//               packed record type for downstream stages.
// Revision    : 1.0 - initial release
// ============================================================================
package graph_pkg;

    localparam int DIM_DEFAULT   = 4;
    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ID  = 3'd1,
        POP_POS  = 3'd2,
        WAIT_POS = 3'd3,
        EMIT     = 3'd4
    } drain_state_t;

    // One neighbor record: ID plus its position words, word k in pos[k].
    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0]                  id;
        logic [DIM_DEFAULT-1:0][WIDTH_DEFAULT-1:0] pos;
    } graph_record_t;

    // Width of a word index able to address DIM slots (at least one bit).
    function automatic int idx_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/graph_record_drain_pop_tracker.sv
`default_nettype none
// ============================================================================
// Module      : pop_tracker
// Description : Pop-side bookkeeping for one FIFO. Issues a single-cycle pop
//               pulse when requested and allowed, keeps the outstanding flag
//               until the FIFO answers, and flags answers nobody asked for.
// Revision    : 1.0 - initial release
// ============================================================================
module pop_tracker
    import graph_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic req_in,         // owner wants to pop this cycle
    input  logic empty_in,       // FIFO empty
    input  logic valid_in,       // FIFO response valid
    output logic deq_out,        // pop pulse
    output logic take_out,       // response belongs to our outstanding pop
    output logic unexpected_out  // response with nothing outstanding
);

    logic outstanding_q, outstanding_d;

    // Pop only when allowed, never during reset, and never with one in flight.
    always_comb begin
        deq_out        = req_in & ~empty_in & ~outstanding_q & ~rst_in;
        take_out       = valid_in & outstanding_q;
        unexpected_out = valid_in & ~outstanding_q;
        outstanding_d  = outstanding_q;
        if (deq_out) begin
            outstanding_d = 1'b1;
        end else if (take_out) begin
            outstanding_d = 1'b0;
        end
    end

    // Outstanding flag register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            outstanding_q <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/graph_record_drain.sv
`default_nettype none
// ============================================================================
// Module      : graph_record_drain
// Description : Reader end of the graph_fetch neighbor and position FIFOs.
//               Pops one neighbor ID then DIM position words, packs them into
//               a record and offers it downstream over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module graph_record_drain
    import graph_pkg::*;
#(
    parameter int DIM   = DIM_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    output logic                 neigh_deq_out,
    input  logic [WIDTH-1:0]     neigh_data_in,
    input  logic                 neigh_valid_in,
    input  logic                 neigh_empty_in,
    output logic                 pos_deq_out,
    input  logic [WIDTH-1:0]     pos_data_in,
    input  logic                 pos_valid_in,
    input  logic                 pos_empty_in,
    output logic [WIDTH-1:0]     rec_id_out,
    output logic [DIM*WIDTH-1:0] rec_pos_out,
    output logic                 rec_valid_out,
    input  logic                 rec_ready_in,
    output logic [31:0]          rec_count_out,
    output logic                 err_out
);

    localparam int IDX_W = idx_width(DIM);

    drain_state_t         state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]     id_q, id_d;
    logic [DIM*WIDTH-1:0] pos_q, pos_d;
    logic [31:0]          count_q, count_d;
    logic                 err_q, err_d;

    logic neigh_req, neigh_take, neigh_unexp;
    logic pos_req, pos_take, pos_unexp;

    pop_tracker u_neigh_trk (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_in         (neigh_req),
        .empty_in       (neigh_empty_in),
        .valid_in       (neigh_valid_in),
        .deq_out        (neigh_deq_out),
        .take_out       (neigh_take),
        .unexpected_out (neigh_unexp)
    );

    pop_tracker u_pos_trk (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_in         (pos_req),
        .empty_in       (pos_empty_in),
        .valid_in       (pos_valid_in),
        .deq_out        (pos_deq_out),
        .take_out       (pos_take),
        .unexpected_out (pos_unexp)
    );

    // Next-state, record assembly and pop requests.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        id_d      = id_q;
        pos_d     = pos_q;
        count_d   = count_q;
        neigh_req = 1'b0;
        pos_req   = 1'b0;
        // Stray responses are ignored by the datapath but remembered forever.
        err_d     = err_q | neigh_unexp | pos_unexp;

        case (state_q)
            IDLE: begin
                neigh_req = 1'b1;
                if (neigh_deq_out) begin
                    state_d = WAIT_ID;
                end
            end
            WAIT_ID: begin
                if (neigh_take) begin
                    id_d    = neigh_data_in;
                    idx_d   = '0;
                    state_d = POP_POS;
                end
            end
            POP_POS: begin
                pos_req = 1'b1;
                if (pos_deq_out) begin
                    state_d = WAIT_POS;
                end
            end
            WAIT_POS: begin
                if (pos_take) begin
                    for (int k = 0; k < DIM; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            pos_d[k*WIDTH +: WIDTH] = pos_data_in;
                        end
                    end
                    if (idx_q == IDX_W'(DIM - 1)) begin
                        state_d = EMIT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = POP_POS;
                    end
                end
            end
            EMIT: begin
                if (rec_ready_in) begin
                    count_d   = count_q + 32'd1;
                    // Start the next record in the accept cycle when possible.
                    neigh_req = 1'b1;
                    state_d   = neigh_deq_out ? WAIT_ID : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and record registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            id_q    <= '0;
            pos_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
            pos_q   <= pos_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Record fields are only written before EMIT, so they hold while stalled.
    always_comb begin
        rec_id_out    = id_q;
        rec_pos_out   = pos_q;
        rec_valid_out = (state_q == EMIT);
        rec_count_out = count_q;
        err_out       = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_graph_record_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_graph_record_drain
// Description : Self-checking bench for graph_record_drain with behavioural
//               neighbor/position FIFOs of programmable response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_graph_record_drain;

    localparam int DIM   = 4;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_in       = 1'b1;
    logic              rec_ready_in = 1'b1;
    logic [WIDTH-1:0]  nm_data = '0, pm_data = '0;
    logic              nm_valid = 1'b0, pm_valid = 1'b0;
    logic              nm_empty = 1'b1, pm_empty = 1'b1;
    logic              inj_pos  = 1'b0;
    logic              fifo_clr = 1'b0;

    wire               neigh_deq_out, pos_deq_out, rec_valid_out, err_out;
    wire [WIDTH-1:0]   rec_id_out;
    wire [31:0]        rec_count_out;
    wire [DIM*WIDTH-1:0] rec_pos_out;
    wire               neigh_valid_in = nm_valid;
    wire               pos_valid_in   = pm_valid | inj_pos;

    graph_record_drain #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .neigh_deq_out  (neigh_deq_out),
        .neigh_data_in  (nm_data),
        .neigh_valid_in (neigh_valid_in),
        .neigh_empty_in (nm_empty),
        .pos_deq_out    (pos_deq_out),
        .pos_data_in    (pm_data),
        .pos_valid_in   (pos_valid_in),
        .pos_empty_in   (pm_empty),
        .rec_id_out     (rec_id_out),
        .rec_pos_out    (rec_pos_out),
        .rec_valid_out  (rec_valid_out),
        .rec_ready_in   (rec_ready_in),
        .rec_count_out  (rec_count_out),
        .err_out        (err_out)
    );

    // ---------------- FIFO models ----------------
    logic [WIDTH-1:0] nq[$];
    logic [WIDTH-1:0] pq[$];
    int n_lat = 1, p_lat = 1;
    int n_cnt = 0, p_cnt = 0;
    logic [WIDTH-1:0] n_hold = '0, p_hold = '0;
    bit n_out = 0, p_out = 0;
    bit n_d, p_d;
    int n_pulses = 0, p_pulses = 0;
    bit n_overlap = 0, p_overlap = 0;

    // Neighbor FIFO: answers a pop n_lat cycles after the pulse.
    always @(posedge clk) begin
        n_d = neigh_deq_out;
        #1;
        if (fifo_clr) begin
            nq.delete();
            n_cnt = 0; n_out = 0; nm_valid = 1'b0;
        end else begin
            if (n_d && n_out) n_overlap = 1;
            if (nm_valid) n_out = 0;
            nm_valid = 1'b0;
            if (n_d) begin
                n_pulses++;
                n_out  = 1;
                n_hold = (nq.size() > 0) ? nq.pop_front() : 32'hBAD0BAD0;
                n_cnt  = n_lat;
            end
            if (n_cnt > 0) begin
                n_cnt--;
                if (n_cnt == 0) begin nm_valid = 1'b1; nm_data = n_hold; end
            end
        end
        nm_empty = (nq.size() == 0);
    end

    // Position FIFO: same model, independent latency.
    always @(posedge clk) begin
        p_d = pos_deq_out;
        #1;
        if (fifo_clr) begin
            pq.delete();
            p_cnt = 0; p_out = 0; pm_valid = 1'b0;
        end else begin
            if (p_d && p_out) p_overlap = 1;
            if (pm_valid) p_out = 0;
            pm_valid = 1'b0;
            if (p_d) begin
                p_pulses++;
                p_out  = 1;
                p_hold = (pq.size() > 0) ? pq.pop_front() : 32'hBAD1BAD1;
                p_cnt  = p_lat;
            end
            if (p_cnt > 0) begin
                p_cnt--;
                if (p_cnt == 0) begin pm_valid = 1'b1; pm_data = p_hold; end
            end
        end
        pm_empty = (pq.size() == 0);
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst_in   = 1'b1;
        fifo_clr = 1'b1;
        repeat (n) @(negedge clk);
        rst_in   = 1'b0;
        fifo_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] id, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
        nq.push_back(id);
        pq.push_back(w0); pq.push_back(w1); pq.push_back(w2); pq.push_back(w3);
    endtask

    // Follows one record from its neighbor pop to acceptance (rec_ready_in=1).
    task automatic run_record(input string tag, input logic [31:0] exp_id,
                              input logic [127:0] exp_pos, input int exp_cyc,
                              input logic [31:0] exp_count, input logic exp_err);
        int t, cyc, nb, pb;
        nb = n_pulses; pb = p_pulses;
        t = 0;
        while (!neigh_deq_out && t < 20) begin @(negedge clk); t++; end
        chk({tag, "_start"}, neigh_deq_out, 1'b1);
        cyc = 0;
        while (!rec_valid_out && cyc < 200) begin @(negedge clk); cyc++; end
        chk({tag, "_latency"}, cyc, exp_cyc);
        chk({tag, "_id"}, rec_id_out, exp_id);
        chk({tag, "_pos"}, rec_pos_out, exp_pos);
        chk({tag, "_npulses"}, n_pulses - nb, 1);
        chk({tag, "_ppulses"}, p_pulses - pb, 4);
        chk({tag, "_err"}, err_out, exp_err);
        @(negedge clk);
        chk({tag, "_valid_drop"}, rec_valid_out, 1'b0);
        chk({tag, "_count"}, rec_count_out, exp_count);
    endtask

    typedef struct {
        logic [31:0]  id;
        logic [31:0]  w[4];
        int           lat;
        logic [31:0]  exp_id;
        logic [127:0] exp_pos;
        int           exp_cyc;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int t, cyc, nb, pb;
        bit ok;

        vecs[0] = '{id: 32'd55, w: '{32'd10, 32'd11, 32'd12, 32'd13}, lat: 1, exp_id: 32'd55,
                    exp_pos: 128'h0000000d_0000000c_0000000b_0000000a, exp_cyc: 10};
        vecs[1] = '{id: 32'd55, w: '{32'd10, 32'd11, 32'd12, 32'd13}, lat: 3, exp_id: 32'd55,
                    exp_pos: 128'h0000000d_0000000c_0000000b_0000000a, exp_cyc: 20};
        vecs[2] = '{id: 32'hdeadbeef, w: '{32'hffffffff, 32'h0, 32'h12345678, 32'h80000001},
                    lat: 2, exp_id: 32'hdeadbeef,
                    exp_pos: 128'h80000001_12345678_00000000_ffffffff, exp_cyc: 15};

        // Reset state
        do_reset(3);
        chk("rst_valid", rec_valid_out, 1'b0);
        chk("rst_id", rec_id_out, 32'd0);
        chk("rst_pos", rec_pos_out, 128'd0);
        chk("rst_count", rec_count_out, 32'd0);
        chk("rst_err", err_out, 1'b0);
        chk("rst_deq", {neigh_deq_out, pos_deq_out}, 2'b00);

        // Table-driven single records at several latencies
        for (int i = 0; i < 3; i++) begin
            n_lat = vecs[i].lat;
            p_lat = vecs[i].lat;
            load(vecs[i].id, vecs[i].w[0], vecs[i].w[1], vecs[i].w[2], vecs[i].w[3]);
            run_record($sformatf("vec%0d", i), vecs[i].exp_id, vecs[i].exp_pos,
                       vecs[i].exp_cyc, 32'(i + 1), 1'b0);
        end

        // Downstream stall with a second record queued, then back-to-back
        n_lat = 1; p_lat = 1;
        rec_ready_in = 1'b0;
        load(32'd1, 32'd100, 32'd101, 32'd102, 32'd103);
        load(32'd64, 32'd200, 32'd201, 32'd202, 32'd203);
        t = 0;
        while (!rec_valid_out && t < 100) begin @(negedge clk); t++; end
        chk("stall_valid", rec_valid_out, 1'b1);
        chk("stall_id", rec_id_out, 32'd1);
        nb = n_pulses; pb = p_pulses;
        ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (!rec_valid_out || rec_id_out != 32'd1 ||
                rec_pos_out != 128'h00000067_00000066_00000065_00000064) ok = 0;
        end
        chk("stall_stable", ok, 1'b1);
        chk("stall_no_npulse", n_pulses - nb, 0);
        chk("stall_no_ppulse", p_pulses - pb, 0);
        rec_ready_in = 1'b1;
        #1;
        chk("fastpath_deq", neigh_deq_out, 1'b1);
        @(negedge clk);
        chk("fastpath_valid_low", rec_valid_out, 1'b0);
        chk("fastpath_count", rec_count_out, 32'd4);
        cyc = 1;
        while (!rec_valid_out && cyc < 200) begin @(negedge clk); cyc++; end
        chk("b2b_latency", cyc, 10);
        chk("b2b_id", rec_id_out, 32'd64);
        chk("b2b_pos", rec_pos_out, 128'h000000cb_000000ca_000000c9_000000c8);
        @(negedge clk);
        chk("b2b_count", rec_count_out, 32'd5);

        // Position FIFO runs dry after two words
        pb = p_pulses;
        nq.push_back(32'd7);
        pq.push_back(32'd21); pq.push_back(32'd22);
        t = 0;
        while ((p_pulses - pb) < 2 && t < 100) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        ok = 1;
        repeat (15) begin
            @(negedge clk);
            if (pos_deq_out || rec_valid_out) ok = 0;
        end
        chk("dry_hold", ok, 1'b1);
        chk("dry_ppulses", p_pulses - pb, 2);
        pq.push_back(32'd23); pq.push_back(32'd24);
        t = 0;
        while (!rec_valid_out && t < 100) begin @(negedge clk); t++; end
        chk("dry_id", rec_id_out, 32'd7);
        chk("dry_pos", rec_pos_out, 128'h00000018_00000017_00000016_00000015);
        @(negedge clk);
        chk("dry_count", rec_count_out, 32'd6);

        // Unsolicited position response while idle
        @(negedge clk);
        inj_pos = 1'b1;
        @(negedge clk);
        inj_pos = 1'b0;
        chk("unsol_err", err_out, 1'b1);
        chk("unsol_valid", rec_valid_out, 1'b0);
        load(32'd9, 32'd1, 32'd2, 32'd3, 32'd4);
        run_record("after_err", 32'd9, 128'h00000004_00000003_00000002_00000001, 10, 32'd7, 1'b1);
        do_reset(2);
        chk("clr_err", err_out, 1'b0);
        chk("clr_count", rec_count_out, 32'd0);

        // Reset while waiting for position word 1
        n_lat = 2; p_lat = 2;
        pb = p_pulses;
        load(32'd3, 32'd5, 32'd6, 32'd7, 32'd8);
        t = 0;
        while ((p_pulses - pb) < 2 && t < 100) begin @(negedge clk); t++; end
        rst_in = 1'b1;
        @(negedge clk);
        chk("midrst_outputs",
            {rec_valid_out, rec_id_out, rec_pos_out, rec_count_out, err_out, neigh_deq_out, pos_deq_out},
            '0);
        repeat (4) @(negedge clk);
        do_reset(2);
        chk("midrst_err", err_out, 1'b0);
        n_lat = 1; p_lat = 1;
        load(32'd77, 32'd30, 32'd31, 32'd32, 32'd33);
        run_record("fresh", 32'd77, 128'h00000021_00000020_0000001f_0000001e, 10, 32'd1, 1'b0);

        chk("no_neigh_overlap", n_overlap, 1'b0);
        chk("no_pos_overlap", p_overlap, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
